// File: rtl/piece_coord_seq_pkg.sv
// piece_coord_seq_pkg: shared widths, piece index type, FSM states and the degree sine helper
`ifndef INT_BITS
`define INT_BITS 16
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
package piece_coord_seq_pkg;
  localparam int NUM_PIECES_DEF = 7;
  localparam int INT_BITS_P = `INT_BITS;
  localparam int FLOAT_BITS_P = `FLOAT_BITS;
  localparam int FRAC_BITS = `FLOAT_BITS - `INT_BITS;
  localparam int TRIG_BITS = 14;
  typedef logic [$clog2(NUM_PIECES_DEF)-1:0] piece_idx_t;
  typedef enum logic {IDLE, ISSUE} state_t;
  function automatic logic signed [15:0] sin_deg(input int a);
    int m, t, p, r;
    m = a % 360;
    m = m < 0 ? m + 360 : m;
    t = m < 180 ? m : m - 180;
    p = t * (180 - t);
    r = (p * 65536) / (40500 - p);
    sin_deg = 16'(m < 180 ? r : -r);
  endfunction
endpackage

// File: rtl/piece_coord_seq_rotate.sv
// piece_coord_seq_rotate: combinational rotation of a fixed-point offset by an angle in degrees
module piece_coord_seq_rotate
  import piece_coord_seq_pkg::*;
(
  input  logic signed [`FLOAT_BITS-1:0] x,
  input  logic signed [`FLOAT_BITS-1:0] y,
  input  logic signed [`INT_BITS-1:0]   angle,
  output logic signed [`FLOAT_BITS-1:0] x1,
  output logic signed [`FLOAT_BITS-1:0] y1
);
  localparam int PW = `FLOAT_BITS + 16;
  logic signed [15:0] s, c;
  // x1 = x*cos + y*sin, y1 = -x*sin + y*cos with Q2.14 trig values
  always_comb begin
    s = sin_deg(int'(angle));
    c = sin_deg(int'(angle) + 90);
    x1 = `FLOAT_BITS'((PW'(x) * PW'(c) + PW'(y) * PW'(s)) >>> TRIG_BITS);
    y1 = `FLOAT_BITS'((PW'(y) * PW'(c) - PW'(x) * PW'(s)) >>> TRIG_BITS);
  end
endmodule

// File: rtl/piece_coord_seq.sv
// piece_coord_seq: per-pixel sequencer emitting one rotated piece-relative offset beat per piece
module piece_coord_seq
  import piece_coord_seq_pkg::*;
#(
  parameter int NUM_PIECES = NUM_PIECES_DEF,
  parameter int COORD_BITS = 11,
  localparam int PW = NUM_PIECES > 1 ? $clog2(NUM_PIECES) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [COORD_BITS-1:0]            in_px,
  input  logic [COORD_BITS-1:0]            in_py,
  input  logic [NUM_PIECES*COORD_BITS-1:0] piece_cx,
  input  logic [NUM_PIECES*COORD_BITS-1:0] piece_cy,
  input  logic [NUM_PIECES*`INT_BITS-1:0]  piece_angle,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PW-1:0]                    out_piece,
  output logic signed [`FLOAT_BITS-1:0]    out_x,
  output logic signed [`FLOAT_BITS-1:0]    out_y,
  output logic                             out_last
);
  state_t state_q, state_d;
  logic [PW-1:0] k_q, k_d, out_piece_q, out_piece_d;
  logic [COORD_BITS-1:0] px_q, px_d, py_q, py_d, cx_k, cy_k;
  logic signed [`INT_BITS-1:0] ang_k;
  logic signed [COORD_BITS:0] dx, dy;
  logic signed [`FLOAT_BITS-1:0] dxf, dyf, rx, ry, out_x_q, out_x_d, out_y_q, out_y_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic load, last, accept;
  piece_coord_seq_rotate u_rot (.x(dxf), .y(dyf), .angle(ang_k), .x1(rx), .y1(ry));
  // select piece k, form the offset in the integer field and compute next state
  always_comb begin
    cx_k = piece_cx[k_q*COORD_BITS +: COORD_BITS];
    cy_k = piece_cy[k_q*COORD_BITS +: COORD_BITS];
    ang_k = piece_angle[k_q*`INT_BITS +: `INT_BITS];
    dx = {1'b0, px_q} - {1'b0, cx_k};
    dy = {1'b0, py_q} - {1'b0, cy_k};
    dxf = `FLOAT_BITS'(dx) <<< FRAC_BITS;
    dyf = `FLOAT_BITS'(dy) <<< FRAC_BITS;
    accept = state_q == IDLE && in_valid;
    load = state_q == ISSUE && (!out_valid_q || out_ready);
    last = k_q == PW'(NUM_PIECES - 1);
    state_d = accept ? ISSUE : (load && last) ? IDLE : state_q;
    k_d = accept ? '0 : load ? (last ? '0 : k_q + 1'b1) : k_q;
    px_d = accept ? in_px : px_q;
    py_d = accept ? in_py : py_q;
    in_ready_d = state_d == IDLE;
    out_valid_d = load | (out_valid_q & ~out_ready);
    out_piece_d = load ? k_q : out_piece_q;
    out_last_d = load ? last : out_last_q;
    out_x_d = load ? rx : out_x_q;
    out_y_d = load ? ry : out_y_q;
  end
  // FSM, index counter, latched pixel and registered output beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      px_q <= '0;
      py_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_piece_q <= '0;
      out_last_q <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      px_q <= px_d;
      py_q <= py_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_piece_q <= out_piece_d;
      out_last_q <= out_last_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
    end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_piece = out_piece_q;
  assign out_last = out_last_q;
  assign out_x = out_x_q;
  assign out_y = out_y_q;
endmodule
